// File: rtl/bow_pkg.sv
// Shared types and constants for the bow draw controller and the sprite-select mux.
package bow_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAW     = 2'd1,
    HOLD     = 2'd2,
    COOLDOWN = 2'd3
  } bow_state_t;

  typedef logic [1:0] bow_frame_t;

  localparam bow_frame_t BOW_REST   = 2'd0;
  localparam bow_frame_t BOW_STAGE1 = 2'd1;
  localparam bow_frame_t BOW_STAGE2 = 2'd2;
  localparam bow_frame_t BOW_FULL   = 2'd3;

  localparam logic [1:0] POWER_PARTIAL = 2'd2;
  localparam logic [1:0] POWER_FULL    = 2'd3;

endpackage

// File: rtl/bow_draw_ctrl_if.sv
// Frame/button inputs and sprite/shot outputs of the bow draw controller.
interface bow_draw_ctrl_if;
  import bow_pkg::*;

  logic       frame_start;
  logic       btn;
  logic       arrow_busy;
  bow_frame_t bow_frame;
  logic       charging;
  logic       fire;
  logic [1:0] fire_power;

  modport master (
    output frame_start, btn, arrow_busy,
    input  bow_frame, charging, fire, fire_power
  );

  modport slave (
    input  frame_start, btn, arrow_busy,
    output bow_frame, charging, fire, fire_power
  );
endinterface

// File: rtl/bow_draw_ctrl.sv
// Bow draw-and-release FSM: turns the fire button into a frame-synchronous
// sprite stage and a one-cycle fire strobe with shot power.
module bow_draw_ctrl
  import bow_pkg::*;
#(
  parameter int STAGE_FRAMES    = 12,
  parameter int COOLDOWN_FRAMES = 20
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  bow_draw_ctrl_if.slave   bus
);

  localparam int MAX_FRAMES = (STAGE_FRAMES > COOLDOWN_FRAMES) ? STAGE_FRAMES : COOLDOWN_FRAMES;
  localparam int CW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_FRAMES - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_FRAMES - 1);

  bow_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  bow_frame_t    bow, bow_n;
  logic          charging, charging_n;
  logic          fire, fire_n;
  logic [1:0]    power, power_n;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bow      <= BOW_REST;
      charging <= 1'b0;
      fire     <= 1'b0;
      power    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bow      <= bow_n;
      charging <= charging_n;
      fire     <= fire_n;
      power    <= power_n;
    end
  end

  // Inputs only matter on frame_start, so the sprite changes only during vblank.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bow_n   = bow;
    fire_n  = 1'b0;
    power_n = power;
    if (bus.frame_start) begin
      case (state)
        IDLE: begin
          if (bus.btn && !bus.arrow_busy) begin
            state_n = DRAW;
            cnt_n   = '0;
            bow_n   = BOW_STAGE1;
          end
        end
        DRAW: begin
          if (!bus.btn) begin
            cnt_n = '0;
            bow_n = BOW_REST;
            if (bow == BOW_STAGE1) begin
              state_n = IDLE;
            end else begin
              state_n = COOLDOWN;
              fire_n  = 1'b1;
              power_n = POWER_PARTIAL;
            end
          end else if (cnt == STAGE_LAST) begin
            cnt_n = '0;
            bow_n = bow + 2'd1;
            if (bow_n == BOW_FULL) state_n = HOLD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!bus.btn) begin
            state_n = COOLDOWN;
            cnt_n   = '0;
            bow_n   = BOW_REST;
            fire_n  = 1'b1;
            power_n = POWER_FULL;
          end
        end
        COOLDOWN: begin
          if (cnt == COOL_LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    charging_n = (state_n == DRAW) || (state_n == HOLD);
  end

  assign bus.bow_frame  = bow;
  assign bus.charging   = charging;
  assign bus.fire       = fire;
  assign bus.fire_power = power;

endmodule
